fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage feeding the control decoder and datapath of the 9-bit-instruction processor.
- Owns the program counter and drives the instruction-ROM address.
- Registers the returned instruction into an instruction register (IR) for decode.
- Resolves taken branches (EQ) and jumps (JAL) with a one-bubble flush, and generates program Start/Done sequencing.

Parameters:
- PC_W, 10, program counter / instruction address width
- INSTR_W, 9, instruction width

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle pulse; begins a program at StartAddr
- StartAddr  in  PC_W  first instruction address
- EndAddr  in  PC_W  address one past the last instruction
- Stall  in  1  freeze PC, IR and state this cycle
- ProgCode  in  INSTR_W  ROM data for address PC (combinational ROM, same cycle)
- Branch  in  1  decoder branch flag for the IR instruction
- Zero  in  1  ALU equal flag for the IR instruction
- Jump  in  1  decoder jump flag for the IR instruction
- BranchTarget  in  PC_W  absolute branch target (from target LUT)
- JumpTarget  in  PC_W  absolute jump target (register value)
- PC  out  PC_W  instruction-ROM address
- Instr  out  INSTR_W  IR contents to control decoder
- InstrValid  out  1  IR holds a live instruction
- LinkAddr  out  PC_W  IR_PC+1, return address for JAL writeback
- Done  out  1  program finished

Behaviour:
- Reset (async, Reset=1): state=IDLE, PC=0, Instr=0, IR_PC=0, InstrValid=0, Done=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs held.
  - Start=1 -> PC<=StartAddr, InstrValid<=0, Done<=0, go RUN.
- RUN, Stall=0, evaluated in priority order:
  1. Redirect, when InstrValid=1 and (Jump=1, or Branch=1 and Zero=1):
     - PC<=JumpTarget if Jump=1, else BranchTarget (Jump wins if both).
     - InstrValid<=0; the bubble discards the word fetched this cycle.
     - Stay RUN.
  2. PC==EndAddr:
     - InstrValid<=0, Done<=1, go DONE.
     - The instruction currently in IR still completes this cycle.
  3. Otherwise:
     - Instr<=ProgCode, IR_PC<=PC, InstrValid<=1.
     - PC<=PC+1, modulo 2^PC_W (1023+1 -> 0).
- Branch/Jump/Zero are ignored when InstrValid=0.
- RUN, Stall=1: PC, Instr, IR_PC, InstrValid and state all hold; redirect is deferred (control inputs remain stable until Stall drops).
- Start while in RUN is ignored.
- DONE:
  - Done=1 held, InstrValid=0, PC frozen.
  - Start=1 -> Done<=0, PC<=StartAddr, go RUN.
  - Stall has no effect in IDLE or DONE.
- Latency:
  - An instruction at address A appears on Instr one cycle after PC=A.
  - A taken branch costs exactly one bubble cycle.
- LinkAddr = IR_PC+1, modulo 2^PC_W, combinational from IR_PC.
- Start with StartAddr==EndAddr: enter RUN, then DONE on the next cycle; zero instructions issue.
- Reset mid-program aborts immediately to IDLE values; no Done pulse.

Test Plan:
1. Reset=1 for 2 cycles, then release -> PC=0, InstrValid=0, Done=0, state IDLE. Start without Reset asserted later -> PC=0x005 next cycle when StartAddr=0x005.
2. Straight line: StartAddr=0, EndAddr=3, ROM[0..2]=0x101,0x0A2,0x1FF.
   - Instr shows 0x101, 0x0A2, 0x1FF on consecutive cycles, each with InstrValid=1.
   - Next cycle: Done=1, InstrValid=0.
3. Taken EQ: IR holds the instruction at 0x004, Branch=1, Zero=1, BranchTarget=0x010.
   - Next cycle: PC=0x010, InstrValid=0.
   - Following cycle: Instr=ROM[0x010], InstrValid=1.
   - With Zero=0 instead: PC advances to 0x006, no bubble.
4. JAL: IR_PC=0x020, Jump=1, JumpTarget=0x100 -> LinkAddr=0x021 during that cycle; PC=0x100 next cycle, one bubble.
5. Stall=1 for 3 cycles mid-program with Branch=1, Zero=1 -> PC/Instr unchanged for all 3 cycles; redirect occurs on the first cycle with Stall=0.
6. Edge cases, each checked separately:
   - PC=0x3FF, EndAddr=0x000 -> PC wraps to 0x000, then Done=1.
   - Redirect issued while PC==EndAddr -> redirect wins, Done stays 0.
   - Reset asserted in RUN -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch-stage signals shared between the fetch unit and its
// surroundings (decoder, ALU flags, instruction ROM, program sequencer).
//
// Handshake semantics: Start is a single-cycle request accepted only in
// IDLE or DONE; Done stays high until the next accepted Start.
// InstrValid qualifies Instr/LinkAddr every cycle, and Branch/Zero/Jump
// are only honoured while InstrValid is high. Stall freezes the stage,
// and the control inputs must stay stable until it drops.
interface fetch_unit_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
);
  logic               Start;
  logic [PC_W-1:0]    StartAddr;
  logic [PC_W-1:0]    EndAddr;
  logic               Stall;
  logic [INSTR_W-1:0] ProgCode;
  logic               Branch;
  logic               Zero;
  logic               Jump;
  logic [PC_W-1:0]    BranchTarget;
  logic [PC_W-1:0]    JumpTarget;
  logic [PC_W-1:0]    PC;
  logic [INSTR_W-1:0] Instr;
  logic               InstrValid;
  logic [PC_W-1:0]    LinkAddr;
  logic               Done;
  logic [1:0]         DbgState;   // 0=IDLE, 1=RUN, 2=DONE

  // Fetch unit side
  modport slave (
    input  Start, StartAddr, EndAddr, Stall, ProgCode,
           Branch, Zero, Jump, BranchTarget, JumpTarget,
    output PC, Instr, InstrValid, LinkAddr, Done, DbgState
  );

  // Environment side (sequencer, decoder, ROM)
  modport master (
    output Start, StartAddr, EndAddr, Stall, ProgCode,
           Branch, Zero, Jump, BranchTarget, JumpTarget,
    input  PC, Instr, InstrValid, LinkAddr, Done, DbgState
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers ROM data into the IR,
// resolves taken branches / jumps with a single bubble and sequences
// program Start/Done.
module fetch_unit #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
) (
  input  logic         Clk,
  input  logic         Reset,
  fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_ir, w_ir_nxt;
  logic [PC_W-1:0]    r_ir_pc, w_ir_pc_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_done, w_done_nxt;
  logic               w_redirect;

  // A redirect only counts when the IR holds a live instruction.
  assign w_redirect = r_valid & (bus.Jump | (bus.Branch & bus.Zero));

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_ir_pc <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_ir_pc <= w_ir_pc_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-datapath decision; everything holds by default.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_ir_pc_nxt = r_ir_pc;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    case (r_state)
      IDLE: begin
        if (bus.Start) begin
          w_pc_nxt    = bus.StartAddr;
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (!bus.Stall) begin
          if (w_redirect) begin
            // Word fetched this cycle is dropped: that is the bubble.
            w_pc_nxt    = bus.Jump ? bus.JumpTarget : bus.BranchTarget;
            w_valid_nxt = 1'b0;
          end else if (r_pc == bus.EndAddr) begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_ir_nxt    = bus.ProgCode;
            w_ir_pc_nxt = r_pc;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = r_pc + PC_W'(1);
          end
        end
      end
      DONE: begin
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b1;
        if (bus.Start) begin
          w_done_nxt  = 1'b0;
          w_pc_nxt    = bus.StartAddr;
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // Output drive; LinkAddr wraps with the PC width.
  assign bus.PC         = r_pc;
  assign bus.Instr      = r_ir;
  assign bus.InstrValid = r_valid;
  assign bus.LinkAddr   = r_ir_pc + PC_W'(1);
  assign bus.Done       = r_done;
  assign bus.DbgState   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: linear sequence of steps with
// hand-computed expectations checked by immediate assertions.
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [INSTR_W-1:0] rom [0:1023];

  fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction ROM model
  always_comb bus.ProgCode = rom[bus.PC];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [9:0] pc, input logic [8:0] instr,
                         input logic vld, input logic done, input logic [1:0] st);
    chk({tag, ".pc"},    32'(bus.PC),         32'(pc));
    chk({tag, ".instr"}, 32'(bus.Instr),      32'(instr));
    chk({tag, ".valid"}, 32'(bus.InstrValid), 32'(vld));
    chk({tag, ".done"},  32'(bus.Done),       32'(done));
    chk({tag, ".state"}, 32'(bus.DbgState),   32'(st));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[10'h000] = 9'h101;
    rom[10'h001] = 9'h0A2;
    rom[10'h002] = 9'h1FF;
    rom[10'h004] = 9'h044;
    rom[10'h005] = 9'h055;
    rom[10'h010] = 9'h110;
    rom[10'h011] = 9'h111;
    rom[10'h020] = 9'h120;
    rom[10'h030] = 9'h130;
    rom[10'h040] = 9'h140;
    rom[10'h100] = 9'h0C3;
    rom[10'h3FF] = 9'h1AB;

    bus.Start = 0; bus.StartAddr = '0; bus.EndAddr = '0; bus.Stall = 0;
    bus.Branch = 0; bus.Zero = 0; bus.Jump = 0;
    bus.BranchTarget = '0; bus.JumpTarget = '0;

    // Reset for two cycles
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_out("reset", 10'h000, 9'h000, 0, 0, 2'd0);
    chk("reset.link", 32'(bus.LinkAddr), 32'h001);

    // Start at 0x005 with EndAddr equal: zero instructions, then DONE
    bus.StartAddr = 10'h005; bus.EndAddr = 10'h005; bus.Start = 1;
    tick();
    bus.Start = 0;
    chk_out("start5", 10'h005, 9'h000, 0, 0, 2'd1);
    tick();
    chk_out("empty_prog", 10'h005, 9'h000, 0, 1, 2'd2);

    // Straight-line program 0..2
    bus.StartAddr = 10'h000; bus.EndAddr = 10'h003; bus.Start = 1;
    tick();
    bus.Start = 0;
    chk_out("sl.start", 10'h000, 9'h000, 0, 0, 2'd1);
    tick(); chk_out("sl.i0", 10'h001, 9'h101, 1, 0, 2'd1);
    chk("sl.link0", 32'(bus.LinkAddr), 32'h001);
    tick(); chk_out("sl.i1", 10'h002, 9'h0A2, 1, 0, 2'd1);
    tick(); chk_out("sl.i2", 10'h003, 9'h1FF, 1, 0, 2'd1);
    tick(); chk_out("sl.done", 10'h003, 9'h1FF, 0, 1, 2'd2);

    // Taken EQ branch from 0x004 to 0x010
    bus.StartAddr = 10'h004; bus.EndAddr = 10'h3F0; bus.Start = 1;
    tick();
    bus.Start = 0;
    tick(); chk_out("br.ir4", 10'h005, 9'h044, 1, 0, 2'd1);
    bus.Branch = 1; bus.Zero = 1; bus.BranchTarget = 10'h010;
    tick(); chk_out("br.bubble", 10'h010, 9'h044, 0, 0, 2'd1);
    bus.Branch = 0; bus.Zero = 0;
    tick(); chk_out("br.target", 10'h011, 9'h110, 1, 0, 2'd1);

    // Start while running is ignored
    bus.StartAddr = 10'h200; bus.Start = 1;
    tick();
    bus.Start = 0;
    chk_out("run.start_ign", 10'h012, 9'h111, 1, 0, 2'd1);

    // Not-taken branch: jump back to 0x004 first, then Branch=1 Zero=0
    bus.Jump = 1; bus.JumpTarget = 10'h004;
    tick(); chk_out("nt.jmp", 10'h004, 9'h111, 0, 0, 2'd1);
    bus.Jump = 0;
    tick(); chk_out("nt.ir4", 10'h005, 9'h044, 1, 0, 2'd1);
    bus.Branch = 1; bus.Zero = 0; bus.BranchTarget = 10'h010;
    tick(); chk_out("nt.fall", 10'h006, 9'h055, 1, 0, 2'd1);
    bus.Branch = 0;

    // JAL from IR_PC=0x020 to 0x100
    bus.Jump = 1; bus.JumpTarget = 10'h020;
    tick();
    bus.Jump = 0;
    tick(); chk_out("jal.ir20", 10'h021, 9'h120, 1, 0, 2'd1);
    chk("jal.link", 32'(bus.LinkAddr), 32'h021);
    bus.Jump = 1; bus.JumpTarget = 10'h100;
    // Jump also beats a simultaneous taken branch
    bus.Branch = 1; bus.Zero = 1; bus.BranchTarget = 10'h010;
    tick(); chk_out("jal.bubble", 10'h100, 9'h120, 0, 0, 2'd1);
    bus.Jump = 0; bus.Branch = 0; bus.Zero = 0;
    tick(); chk_out("jal.target", 10'h101, 9'h0C3, 1, 0, 2'd1);

    // Stall for three cycles with a pending taken branch
    bus.Branch = 1; bus.Zero = 1; bus.BranchTarget = 10'h010; bus.Stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out("stall", 10'h101, 9'h0C3, 1, 0, 2'd1);
    end
    bus.Stall = 0;
    tick(); chk_out("stall.redir", 10'h010, 9'h0C3, 0, 0, 2'd1);
    bus.Branch = 0; bus.Zero = 0;
    tick(); chk_out("stall.target", 10'h011, 9'h110, 1, 0, 2'd1);

    // PC wrap 0x3FF -> 0x000 with EndAddr=0
    bus.EndAddr = 10'h000; bus.Jump = 1; bus.JumpTarget = 10'h3FF;
    tick(); chk_out("wrap.jmp", 10'h3FF, 9'h110, 0, 0, 2'd1);
    bus.Jump = 0;
    tick(); chk_out("wrap.pc", 10'h000, 9'h1AB, 1, 0, 2'd1);
    chk("wrap.link", 32'(bus.LinkAddr), 32'h000);
    tick(); chk_out("wrap.done", 10'h000, 9'h1AB, 0, 1, 2'd2);

    // Redirect at PC==EndAddr wins over Done
    bus.StartAddr = 10'h030; bus.EndAddr = 10'h031; bus.Start = 1;
    tick();
    bus.Start = 0;
    tick(); chk_out("rend.ir30", 10'h031, 9'h130, 1, 0, 2'd1);
    bus.Branch = 1; bus.Zero = 1; bus.BranchTarget = 10'h040;
    tick(); chk_out("rend.redir", 10'h040, 9'h130, 0, 0, 2'd1);
    bus.Branch = 0; bus.Zero = 0; bus.EndAddr = 10'h041;
    tick(); chk_out("rend.ir40", 10'h041, 9'h140, 1, 0, 2'd1);
    tick(); chk_out("rend.done", 10'h041, 9'h140, 0, 1, 2'd2);

    // Stall ignored in DONE; honoured once in RUN
    bus.Stall = 1; bus.StartAddr = 10'h050; bus.Start = 1;
    tick(); chk_out("done.stall_start", 10'h050, 9'h140, 0, 0, 2'd1);
    bus.Start = 0;
    tick(); chk_out("run.stall_hold", 10'h050, 9'h140, 0, 0, 2'd1);
    bus.Stall = 0;
    tick(); chk_out("run.ir50", 10'h051, 9'h000, 1, 0, 2'd1);

    // Asynchronous reset mid-program, checked before any clock edge
    rst = 1'b1;
    #1;
    chk_out("async_rst", 10'h000, 9'h000, 0, 0, 2'd0);
    chk("async_rst.link", 32'(bus.LinkAddr), 32'h001);
    tick();
    rst = 1'b0;

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
